pool_window_3x3: RTL and testbench
==================================

// Module: pool_window_3x3
// PURPOSE
//   Streaming 3x3 window generator that sits directly upstream of the 3x3 FP32 max-finder in the
//   max-pooling path. Accepts one pixel per Valid_In in raster order and buffers two full lines.
//   Emits the 9 pixels of each 3x3 window, stepped by STRIDE, with a single-cycle Valid_Out.
//   Pure data movement: words are opaque DATA_WIDTH-bit patterns; no arithmetic on data.
// PARAMETERS
//   DATA_WIDTH  32  pixel word width (IEEE-754 single in the pooling path)
//   IMG_WIDTH   8   pixels per line, >= 3
//   IMG_HEIGHT  8   lines per frame, >= 3
//   STRIDE      2   window step in both directions, 1 or 2
// PORTS
//   clk         in   1           clock, all state on rising edge
//   rst         in   1           asynchronous reset, active-high
//   Data_In     in   DATA_WIDTH  incoming pixel
//   Valid_In    in   1           Data_In is valid this cycle; there is no backpressure
//   Start_In    in   1           qualified by Valid_In: this pixel is (row 0, col 0) of a new frame
//   Data_Out0..Data_Out8  out  DATA_WIDTH each  window, row-major; 0 = top-left, 8 = bottom-right
//   Valid_Out   out  1           Data_Out0..8 hold a complete window (one-cycle pulse)
//   Frame_Done  out  1           pulses together with Valid_Out on the last window of the frame
// BEHAVIOUR
//   - Reset (async, any time): col/row counters = 0, line buffers and window regs = 0,
//     Data_Out* = 0, Valid_Out = 0, Frame_Done = 0. A partially received frame is discarded.
//   - Storage: two line buffers of IMG_WIDTH words (line n-1 and line n-2), written at the col
//     index, plus a 3x3 window shift register. Depth is a shift or circular buffer.
//   - Each accepted pixel P at (r,c), i.e. a Valid_In cycle, does the following:
//     - Shift the window left one column.
//     - Load the new right column = {lineN2[c], lineN1[c], P}.
//     - Write lineN2[c] <= lineN1[c] and lineN1[c] <= P.
//   - No pixel accepted (Valid_In = 0): all state holds, Valid_Out = 0.
//   - Window emit: on accepting (r,c), the window is valid when all of these hold:
//     r >= 2, c >= 2, (r-2) % STRIDE == 0, (c-2) % STRIDE == 0.
//     Then Valid_Out = 1 in the following cycle (latency 1 clk, registered), and
//     Data_Out* = pixels (r-2..r, c-2..c) held until the next emitted window.
//   - Columns that do not fit a full window at line end (IMG_WIDTH-3 not a multiple of STRIDE)
//     and trailing rows that do not fit a full window are dropped. No padding.
//   - Windows per frame = ((IMG_WIDTH-3)/STRIDE + 1) * ((IMG_HEIGHT-3)/STRIDE + 1), floor division.
//   - Counters: col wraps IMG_WIDTH-1 -> 0 with row+1; row wraps IMG_HEIGHT-1 -> 0. The next
//     frame may follow back-to-back with no idle cycle.
//   - Frame_Done = Valid_Out on the window whose bottom-right is the last emittable (r,c).
//   - Start_In with Valid_In forces this pixel to (0,0) regardless of the counters (resync).
//     Window and line contents from the aborted frame are not cleared: they are never emitted,
//     because the emit condition needs r >= 2 in the new frame. Start_In without Valid_In is ignored.
//   - Downstream max-finder consumes Valid_Out / Data_Out* directly; no stall path exists.
// TESTING
//   1. STRIDE=1, 4x4 frame, Data_In = 1..16 every cycle:
//      - 4 windows; first = {1,2,3,5,6,7,9,10,11}, one cycle after pixel 11; last = {6,7,8,10,11,12,14,15,16}.
//      - Frame_Done with the last window only.
//   2. STRIDE=2, 8x8 frame, Data_In = 0..63 with random Valid_In gaps:
//      - Exactly 9 windows; first top-left = 0, second top-left = 2, fourth top-left = 16.
//      - Output identical to the gap-free run.
//   3. STRIDE=2, IMG_WIDTH=8, 8x8 frame:
//      - Column 7 never appears as a window bottom-right (dropped tail).
//      - Window count = 3 per window-row.
//   4. Assert rst mid-frame after 20 pixels, then send a full frame 100..163:
//      - All outputs 0 immediately on rst.
//      - No window contains a value < 100.
//   5. Send 30 pixels, then Start_In+Valid_In with value 200, then a full frame:
//      - Window set and count equal a clean frame.
//      - Nothing emitted before new row 2.
//   6. Two frames back-to-back (second has Start_In on its first pixel):
//      - 2 x window count and 2 Frame_Done pulses.
//      - Second frame's first window contains only second-frame data.

Source files
------------

// File: rtl/pool_window_3x3.sv
// Streaming 3x3 window generator for the max-pooling path: two line buffers plus a
// 3x3 shift window, emitting one registered window per STRIDE step in each direction.
module pool_window_3x3 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int STRIDE     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    input  logic                  Start_In,
    output logic [DATA_WIDTH-1:0] Data_Out0,
    output logic [DATA_WIDTH-1:0] Data_Out1,
    output logic [DATA_WIDTH-1:0] Data_Out2,
    output logic [DATA_WIDTH-1:0] Data_Out3,
    output logic [DATA_WIDTH-1:0] Data_Out4,
    output logic [DATA_WIDTH-1:0] Data_Out5,
    output logic [DATA_WIDTH-1:0] Data_Out6,
    output logic [DATA_WIDTH-1:0] Data_Out7,
    output logic [DATA_WIDTH-1:0] Data_Out8,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] LAST_COL      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] FINAL_WIN_COL = COL_W'(2 + ((IMG_WIDTH - 3) / STRIDE) * STRIDE);
    localparam logic [ROW_W-1:0] FINAL_WIN_ROW = ROW_W'(2 + ((IMG_HEIGHT - 3) / STRIDE) * STRIDE);

    logic [COL_W-1:0]      col_q, col_cur;
    logic [ROW_W-1:0]      row_q, row_cur;
    logic [DATA_WIDTH-1:0] line_n1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line_n2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win      [9];
    logic [DATA_WIDTH-1:0] win_next [9];
    logic [DATA_WIDTH-1:0] out_win  [9];
    logic                  stride_ok;
    logic                  emit;
    logic                  last_win;

    // Start_In resynchronises the current pixel to (0,0); stale buffer contents are harmless
    // because nothing is emitted until row 2 of the new frame.
    always_comb begin
        col_cur = Start_In ? '0 : col_q;
        row_cur = Start_In ? '0 : row_q;

        for (int r = 0; r < 3; r++) begin
            win_next[3*r]   = win[3*r+1];
            win_next[3*r+1] = win[3*r+2];
        end
        win_next[2] = line_n2[col_cur];
        win_next[5] = line_n1[col_cur];
        win_next[8] = Data_In;

        // With STRIDE 2, (x-2) % 2 == 0 reduces to x being even.
        stride_ok = (STRIDE == 1) || (!row_cur[0] && !col_cur[0]);
        emit      = Valid_In && (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2)) && stride_ok;
        last_win  = (row_cur == FINAL_WIN_ROW) && (col_cur == FINAL_WIN_COL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (Valid_In) begin
            if (col_cur == LAST_COL) begin
                col_q <= '0;
                row_q <= (row_cur == LAST_ROW) ? '0 : row_cur + ROW_W'(1);
            end else begin
                col_q <= col_cur + COL_W'(1);
                row_q <= row_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                line_n1[i] <= '0;
                line_n2[i] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else if (Valid_In) begin
            line_n2[col_cur] <= line_n1[col_cur];
            line_n1[col_cur] <= Data_In;
            for (int i = 0; i < 9; i++) begin
                win[i] <= win_next[i];
            end
        end
    end

    // Output window is captured only on emit so it holds until the next window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                out_win[i] <= '0;
            end
        end else begin
            Valid_Out  <= emit;
            Frame_Done <= emit && last_win;
            if (emit) begin
                for (int i = 0; i < 9; i++) begin
                    out_win[i] <= win_next[i];
                end
            end
        end
    end

    assign Data_Out0 = out_win[0];
    assign Data_Out1 = out_win[1];
    assign Data_Out2 = out_win[2];
    assign Data_Out3 = out_win[3];
    assign Data_Out4 = out_win[4];
    assign Data_Out5 = out_win[5];
    assign Data_Out6 = out_win[6];
    assign Data_Out7 = out_win[7];
    assign Data_Out8 = out_win[8];

endmodule

// File: tb/tb_pool_window_3x3.sv
// Bench for pool_window_3x3: an 8x8/STRIDE-2 and a 4x4/STRIDE-1 instance checked every cycle
// against an image-array model, plus literal window expectations.
module tb_pool_window_3x3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din  [2];
    logic        vin  [2];
    logic        sin  [2];
    logic [31:0] dout [2][9];
    logic        vout [2];
    logic        fd   [2];

    always #5 clk = ~clk;

    pool_window_3x3 #(.DATA_WIDTH(32), .IMG_WIDTH(8), .IMG_HEIGHT(8), .STRIDE(2)) dut (
        .clk(clk), .rst(rst), .Data_In(din[0]), .Valid_In(vin[0]), .Start_In(sin[0]),
        .Data_Out0(dout[0][0]), .Data_Out1(dout[0][1]), .Data_Out2(dout[0][2]),
        .Data_Out3(dout[0][3]), .Data_Out4(dout[0][4]), .Data_Out5(dout[0][5]),
        .Data_Out6(dout[0][6]), .Data_Out7(dout[0][7]), .Data_Out8(dout[0][8]),
        .Valid_Out(vout[0]), .Frame_Done(fd[0])
    );

    pool_window_3x3 #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4), .STRIDE(1)) dut_s1 (
        .clk(clk), .rst(rst), .Data_In(din[1]), .Valid_In(vin[1]), .Start_In(sin[1]),
        .Data_Out0(dout[1][0]), .Data_Out1(dout[1][1]), .Data_Out2(dout[1][2]),
        .Data_Out3(dout[1][3]), .Data_Out4(dout[1][4]), .Data_Out5(dout[1][5]),
        .Data_Out6(dout[1][6]), .Data_Out7(dout[1][7]), .Data_Out8(dout[1][8]),
        .Valid_Out(vout[1]), .Frame_Done(fd[1])
    );

    function automatic int pw(int k); return (k == 0) ? 8 : 4; endfunction
    function automatic int ph(int k); return (k == 0) ? 8 : 4; endfunction
    function automatic int ps(int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int wins(int k);
        return ((pw(k) - 3) / ps(k) + 1) * ((ph(k) - 3) / ps(k) + 1);
    endfunction

    // Reference model: remember every pixel of the current frame by (row,col) and, when a
    // pixel completes an emittable window, read the 3x3 block straight out of the image.
    logic [31:0] img [2][8][8];
    int          mr [2], mc [2], wcnt [2];
    logic [31:0] ew [2][9];
    logic        ev [2], efd [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mr[k] <= 0; mc[k] <= 0; wcnt[k] <= 0; ev[k] <= 1'b0; efd[k] <= 1'b0;
                for (int j = 0; j < 9; j++) ew[k][j] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin : per_dut
                int r, c, n;
                logic e;
                ev[k]  <= 1'b0;
                efd[k] <= 1'b0;
                if (vin[k]) begin
                    r = sin[k] ? 0 : mr[k];
                    c = sin[k] ? 0 : mc[k];
                    img[k][r][c] <= din[k];
                    e = (r >= 2) && (c >= 2) && ((r - 2) % ps(k) == 0) && ((c - 2) % ps(k) == 0);
                    n = (r == 0 && c == 0) ? 0 : wcnt[k];
                    if (e) begin
                        n = n + 1;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                ew[k][3*i+j] <= (i == 2 && j == 2) ? din[k] : img[k][r-2+i][c-2+j];
                    end
                    ev[k]   <= e;
                    efd[k]  <= e && (n == wins(k));
                    wcnt[k] <= n;
                    if (c == pw(k) - 1) begin
                        mc[k] <= 0;
                        mr[k] <= (r == ph(k) - 1) ? 0 : r + 1;
                    end else begin
                        mc[k] <= c + 1;
                        mr[k] <= r;
                    end
                end
            end
        end
    end

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] logw [2][128][9];
    int          cnt [2] = '{0, 0};
    int          fdcnt [2] = '{0, 0};
    int          fdlast [2] = '{-1, -1};
    int          base [2] = '{0, 0};
    logic [31:0] ref_win [9][9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic compareCycle();
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("d%0d_valid", k), {31'b0, vout[k]}, {31'b0, ev[k]});
            checkOutput($sformatf("d%0d_done", k), {31'b0, fd[k]}, {31'b0, efd[k]});
            for (int j = 0; j < 9; j++)
                checkOutput($sformatf("d%0d_out%0d", k, j), dout[k][j], ew[k][j]);
            if (vout[k] === 1'b1 && cnt[k] < 128) begin
                for (int j = 0; j < 9; j++) logw[k][cnt[k]][j] = dout[k][j];
                if (fd[k] === 1'b1) begin
                    fdcnt[k]++;
                    fdlast[k] = cnt[k];
                end
                cnt[k]++;
            end
        end
    endtask

    // One clock of stimulus on instance k (the other instance idles), checked at the negedge.
    task automatic applyStimulus(input int k, input logic [31:0] d, input logic v, input logic s);
        for (int i = 0; i < 2; i++) begin
            din[i] = (i == k) ? d : '0;
            vin[i] = (i == k) ? v : 1'b0;
            sin[i] = (i == k) ? s : 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        compareCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 1'b0, 1'b0);
    endtask

    task automatic sendFrame(input int k, input int first, input bit gaps, input bit start);
        for (int i = 0; i < pw(k) * ph(k); i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            applyStimulus(k, 32'(first + i), 1'b1, start && i == 0);
        end
    endtask

    initial begin
        logic [31:0] exp_first [9];
        logic [31:0] exp_last  [9];
        int          ok, n, row2, col7;

        exp_first = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        exp_last  = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        for (int i = 0; i < 2; i++) begin din[i] = '0; vin[i] = 1'b0; sin[i] = 1'b0; end
        @(negedge clk);
        compareCycle();
        rst = 1'b0;
        idle(2);

        // 4x4 STRIDE 1, pixels 1..16
        base[1] = cnt[1];
        for (int i = 1; i <= 16; i++) applyStimulus(1, 32'(i), 1'b1, i == 1);
        idle(3);
        checkOutput("s1_count", 32'(cnt[1] - base[1]), 32'd4);
        checkOutput("s1_done_count", 32'(fdcnt[1]), 32'd1);
        checkOutput("s1_done_index", 32'(fdlast[1] - base[1]), 32'd3);
        for (int j = 0; j < 9; j++) begin
            checkOutput($sformatf("s1_first_%0d", j), logw[1][base[1]][j], exp_first[j]);
            checkOutput($sformatf("s1_last_%0d", j), logw[1][base[1]+3][j], exp_last[j]);
        end

        // 8x8 STRIDE 2, gap-free reference run
        base[0] = cnt[0];
        sendFrame(0, 0, 1'b0, 1'b1);
        idle(3);
        checkOutput("s2_count", 32'(cnt[0] - base[0]), 32'd9);
        checkOutput("s2_first_tl", logw[0][base[0]][0], 32'd0);
        checkOutput("s2_second_tl", logw[0][base[0]+1][0], 32'd2);
        checkOutput("s2_fourth_tl", logw[0][base[0]+3][0], 32'd16);
        row2 = 0; col7 = 0;
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) ref_win[i][j] = logw[0][base[0]+i][j];
            if (logw[0][base[0]+i][8] / 8 == 2) row2++;
            if (logw[0][base[0]+i][8] % 8 == 7) col7++;
        end
        checkOutput("s2_row2_windows", 32'(row2), 32'd3);
        checkOutput("s2_col7_windows", 32'(col7), 32'd0);

        // Same frame with random Valid_In gaps must produce identical windows
        base[0] = cnt[0];
        sendFrame(0, 0, 1'b1, 1'b1);
        idle(3);
        checkOutput("gap_count", 32'(cnt[0] - base[0]), 32'd9);
        for (int i = 0; i < 9; i++) begin
            ok = 1;
            for (int j = 0; j < 9; j++) if (logw[0][base[0]+i][j] !== ref_win[i][j]) ok = 0;
            checkOutput($sformatf("gap_window_%0d", i), 32'(ok), 32'd1);
        end

        // Reset mid-frame after 20 pixels
        for (int i = 0; i < 20; i++) applyStimulus(0, 32'(i), 1'b1, i == 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_valid", {31'b0, vout[0]}, 32'd0);
        checkOutput("rst_done", {31'b0, fd[0]}, 32'd0);
        for (int j = 0; j < 9; j++) checkOutput($sformatf("rst_out%0d", j), dout[0][j], 32'd0);
        @(posedge clk);
        @(negedge clk);
        compareCycle();
        rst = 1'b0;
        base[0] = cnt[0];
        sendFrame(0, 100, 1'b0, 1'b0);
        idle(3);
        checkOutput("post_rst_count", 32'(cnt[0] - base[0]), 32'd9);
        ok = 1;
        for (int i = 0; i < cnt[0] - base[0]; i++)
            for (int j = 0; j < 9; j++) if (logw[0][base[0]+i][j] < 100) ok = 0;
        checkOutput("post_rst_no_stale", 32'(ok), 32'd1);

        // Resync: 30 pixels, then Start_In with 200 as new (0,0), then the rest of the frame
        for (int i = 0; i < 30; i++) applyStimulus(0, 32'(i), 1'b1, i == 0);
        base[0] = cnt[0];
        applyStimulus(0, 32'd200, 1'b1, 1'b1);
        for (int i = 1; i < 64; i++) applyStimulus(0, 32'(i), 1'b1, 1'b0);
        idle(3);
        checkOutput("resync_count", 32'(cnt[0] - base[0]), 32'd9);
        for (int i = 0; i < 9; i++) begin
            ok = 1;
            for (int j = 0; j < 9; j++)
                if (logw[0][base[0]+i][j] !== ((i == 0 && j == 0) ? 32'd200 : ref_win[i][j])) ok = 0;
            checkOutput($sformatf("resync_window_%0d", i), 32'(ok), 32'd1);
        end

        // Two frames back-to-back
        base[0] = cnt[0];
        n = fdcnt[0];
        sendFrame(0, 300, 1'b0, 1'b1);
        sendFrame(0, 400, 1'b0, 1'b1);
        idle(3);
        checkOutput("b2b_count", 32'(cnt[0] - base[0]), 32'd18);
        checkOutput("b2b_done", 32'(fdcnt[0] - n), 32'd2);
        ok = 1;
        for (int j = 0; j < 9; j++)
            if (logw[0][base[0]+9][j] < 400 || logw[0][base[0]+9][j] > 463) ok = 0;
        checkOutput("b2b_second_clean", 32'(ok), 32'd1);

        // Random traffic on both instances with occasional resyncs
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 60) == 0);
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
